// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer memory between the
// display prefetch stream (feeding a small pixel FIFO) and a single writer.
// Reads always win; the writer only gets the memory when the prefetch path
// has nothing to do.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned FRAME_PIX = 307200,
    parameter int unsigned DEPTH     = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              VGA_VS,
    input  logic              Data_Req,
    output logic [23:0]       DATA,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic              wr_ack,
    output logic              underflow,
    output logic              frame_start
);

    localparam int unsigned PIX_W = 24;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_PREFETCH   = 2'd1,
        S_STREAM     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame sync tracking; r_flush is the one-cycle frame restart window.
    logic r_vs_q;
    logic r_flush;
    logic w_vs_rise;

    // Read stream bookkeeping.
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_inflight;
    logic              r_underflow;

    // Pixel FIFO.
    logic [PIX_W-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_underflow_set;
    logic [OCC_W-1:0] w_occ;
    logic             w_rd_room;
    logic             w_wr_in_frame;
    logic             w_prefetch_done;
    logic             w_rd_go;
    logic             w_wr_go;

    assign w_vs_rise       = VGA_VS & ~r_vs_q;
    assign w_empty         = (r_count == '0);
    assign w_occ           = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_rd_room       = (w_occ < FULL_OCC) && (r_rd_addr < FRAME_END);
    assign w_wr_in_frame   = (wr_addr < FRAME_END);
    assign w_prefetch_done = (r_count == FULL_CNT) || ((r_rd_addr == FRAME_END) && !r_inflight);

    // The restart window discards the pending return and ignores pops.
    assign w_push          = r_inflight & ~r_flush;
    assign w_pop           = Data_Req & ~w_empty & ~r_flush;
    assign w_underflow_set = Data_Req & w_empty & ~r_flush;

    assign DATA        = (!w_empty && !r_flush) ? r_fifo[r_rptr] : '0;
    assign underflow   = r_underflow;
    assign frame_start = r_flush;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_WAIT_FRAME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a frame restart overrides everything, else prefetch fills then streams.
    always_comb begin
        w_state_nxt = r_state;
        if (r_flush) begin
            w_state_nxt = S_PREFETCH;
        end else begin
            case (r_state)
                S_WAIT_FRAME: w_state_nxt = S_WAIT_FRAME;
                S_PREFETCH:   if (w_prefetch_done) w_state_nxt = S_STREAM;
                S_STREAM:     w_state_nxt = S_STREAM;
                default:      w_state_nxt = S_WAIT_FRAME;
            endcase
        end
    end

    // Access arbitration and memory strobes; nothing is issued in reset or the restart window.
    always_comb begin
        w_rd_go   = 1'b0;
        w_wr_go   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (Reset_n && !r_flush) begin
            case (r_state)
                S_WAIT_FRAME: w_wr_go = wr_req;
                S_PREFETCH:   w_rd_go = w_rd_room;
                S_STREAM: begin
                    w_rd_go = w_rd_room;
                    w_wr_go = wr_req & ~w_rd_room;
                end
                default: ;
            endcase
        end
        if (w_rd_go) begin
            mem_en   = 1'b1;
            mem_addr = r_rd_addr;
        end else if (w_wr_go && w_wr_in_frame) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
        wr_ack = w_wr_go;
    end

    // Frame sync edge, read address, in-flight tracking and sticky underflow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_q      <= 1'b0;
            r_flush     <= 1'b0;
            r_inflight  <= 1'b0;
            r_rd_addr   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_vs_q     <= VGA_VS;
            r_flush    <= w_vs_rise;
            r_inflight <= w_rd_go;
            if (r_flush) begin
                r_rd_addr <= '0;
            end else if (w_rd_go) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and count; the restart window empties the FIFO.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (r_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small frame (700 pixels) and a
// memory whose read data equals its address.
module tb_vga_fb_arbiter;

    localparam int unsigned ADDR_W    = 19;
    localparam int unsigned FRAME_PIX = 700;
    localparam int unsigned DEPTH     = 16;

    logic              Clk;
    logic              Reset_n;
    logic              VGA_VS;
    logic              Data_Req;
    logic [23:0]       DATA;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_wdata;
    logic [23:0]       mem_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_ack;
    logic              underflow;
    logic              frame_start;

    int errors = 0;
    int checks = 0;

    vga_fb_arbiter #(
        .ADDR_W    (ADDR_W),
        .FRAME_PIX (FRAME_PIX),
        .DEPTH     (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .VGA_VS      (VGA_VS),
        .Data_Req    (Data_Req),
        .DATA        (DATA),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .underflow   (underflow),
        .frame_start (frame_start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory model: memory[i] = i, read data valid the cycle after the strobe.
    always @(posedge Clk) begin
        if (mem_en && !mem_we) mem_rdata <= 24'(mem_addr);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_rdata = 24'h0;
        Reset_n   = 1'b0;
        VGA_VS    = 1'b0;
        Data_Req  = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 19'd5;
        wr_data   = 24'h111111;
        #3;
        // Reset values, with a pending writer that must not reach memory.
        chk("rst_mem_en",    32'(mem_en),      32'd0);
        chk("rst_mem_we",    32'(mem_we),      32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata),   32'd0);
        chk("rst_wr_ack",    32'(wr_ack),      32'd0);
        chk("rst_data",      32'(DATA),        32'd0);
        chk("rst_underflow", 32'(underflow),   32'd0);
        chk("rst_fstart",    32'(frame_start), 32'd0);
        step();
        step();
        Reset_n  = 1'b1;
        wr_req   = 1'b0;
        Data_Req = 1'b0;

        // Writes in WAIT_FRAME: in-frame, first out-of-frame, last in-frame.
        step();
        wr_req = 1'b1; wr_addr = 19'd100; wr_data = 24'hABCDEF;
        #1;
        chk("wf_wr_ack",   32'(wr_ack),    32'd1);
        chk("wf_mem_en",   32'(mem_en),    32'd1);
        chk("wf_mem_we",   32'(mem_we),    32'd1);
        chk("wf_mem_addr", 32'(mem_addr),  32'd100);
        chk("wf_wdata",    32'(mem_wdata), 32'hABCDEF);
        step();
        wr_addr = 19'(FRAME_PIX); wr_data = 24'h123456;
        #1;
        chk("drop_wr_ack", 32'(wr_ack), 32'd1);
        chk("drop_mem_en", 32'(mem_en), 32'd0);
        chk("drop_mem_we", 32'(mem_we), 32'd0);
        step();
        wr_addr = 19'(FRAME_PIX - 1);
        #1;
        chk("last_wr_ack",   32'(wr_ack),   32'd1);
        chk("last_mem_en",   32'(mem_en),   32'd1);
        chk("last_mem_addr", 32'(mem_addr), 32'(FRAME_PIX - 1));
        step();
        wr_req = 1'b0;
        #1;
        chk("idle_wr_ack", 32'(wr_ack), 32'd0);
        chk("idle_mem_en", 32'(mem_en), 32'd0);

        // Frame 1: VS rise, flush window coinciding with Data_Req, prefetch.
        step();
        VGA_VS = 1'b1;
        #1;
        chk("d0_fstart", 32'(frame_start), 32'd0);
        step();
        Data_Req = 1'b1;
        #1;
        chk("d1_fstart", 32'(frame_start), 32'd1);
        chk("d1_mem_en", 32'(mem_en),      32'd0);
        chk("d1_data",   32'(DATA),        32'd0);
        step();
        Data_Req = 1'b0;
        wr_req = 1'b1; wr_addr = 19'd5; wr_data = 24'h0F0F0F;
        #1;
        chk("d2_fstart",    32'(frame_start), 32'd0);
        chk("d2_underflow", 32'(underflow),   32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk("pf_mem_en",   32'(mem_en),   32'd1);
            chk("pf_mem_we",   32'(mem_we),   32'd0);
            chk("pf_mem_addr", 32'(mem_addr), 32'(i));
            chk("pf_wr_ack",   32'(wr_ack),   32'd0);
        end
        step();
        chk("pf_full_mem_en", 32'(mem_en), 32'd0);
        chk("pf_full_wr_ack", 32'(wr_ack), 32'd0);
        step();
        chk("pf_last_mem_en", 32'(mem_en), 32'd0);
        chk("pf_last_wr_ack", 32'(wr_ack), 32'd0);
        step();
        chk("st_full_wr_ack",   32'(wr_ack),   32'd1);
        chk("st_full_mem_we",   32'(mem_we),   32'd1);
        chk("st_full_mem_addr", 32'(mem_addr), 32'd5);

        // Streaming: pixels come out in order; writer starved while reads run.
        step();
        wr_req = 1'b0; Data_Req = 1'b1;
        #1;
        chk("pop0_data", 32'(DATA), 32'd0);
        step();
        wr_req = 1'b1; wr_addr = 19'd9; wr_data = 24'h999999;
        #1;
        chk("pop1_data",   32'(DATA),   32'd1);
        chk("pop1_wr_ack", 32'(wr_ack), 32'd0);
        for (int k = 2; k < int'(FRAME_PIX); k++) begin
            step();
            if (k == 640) begin
                wr_req = 1'b0;
                #1;
            end
            chk("stream_data", 32'(DATA), 32'(k));
            if (k < 640) chk("stream_wr_ack", 32'(wr_ack), 32'd0);
        end
        step();
        Data_Req = 1'b0;
        wr_req = 1'b1; wr_addr = 19'd200; wr_data = 24'h55AA55;
        #1;
        chk("eof_data",      32'(DATA),      32'd0);
        chk("eof_underflow", 32'(underflow), 32'd0);
        chk("eof_wr_ack",    32'(wr_ack),    32'd1);
        chk("eof_mem_we",    32'(mem_we),    32'd1);
        chk("eof_mem_addr",  32'(mem_addr),  32'd200);
        step();
        wr_req = 1'b0; VGA_VS = 1'b0;
        #1;
        chk("eof_idle_mem_en", 32'(mem_en), 32'd0);

        // Frame 2: underflow in prefetch cycle 0, a few pops, then a restart mid-prefetch.
        step();
        VGA_VS = 1'b1;
        #1;
        step();
        chk("f2_fstart", 32'(frame_start), 32'd1);
        step();
        Data_Req = 1'b1;
        #1;
        chk("f2_uf_data",     32'(DATA),     32'd0);
        chk("f2_rd0_mem_addr", 32'(mem_addr), 32'd0);
        chk("f2_rd0_mem_en",  32'(mem_en),   32'd1);
        step();
        Data_Req = 1'b0;
        #1;
        chk("f2_underflow", 32'(underflow), 32'd1);
        step();
        Data_Req = 1'b1;
        #1;
        chk("f2_pop0", 32'(DATA), 32'd0);
        step();
        chk("f2_pop1", 32'(DATA), 32'd1);
        step();
        chk("f2_pop2", 32'(DATA), 32'd2);
        step();
        Data_Req = 1'b0; VGA_VS = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) step();
        // FIFO now holds pixels 3..12 with the read of pixel 13 returning.
        step();
        VGA_VS = 1'b1;
        #1;
        chk("rs_mem_addr", 32'(mem_addr), 32'd14);
        chk("rs_head",     32'(DATA),     32'd3);
        step();
        VGA_VS = 1'b0;
        #1;
        chk("rs_fstart", 32'(frame_start), 32'd1);
        chk("rs_data",   32'(DATA),        32'd0);
        chk("rs_mem_en", 32'(mem_en),      32'd0);
        step();
        chk("rs_rd0_mem_en",   32'(mem_en),   32'd1);
        chk("rs_rd0_mem_addr", 32'(mem_addr), 32'd0);
        chk("rs_empty_data",   32'(DATA),     32'd0);
        step();
        chk("rs_empty2_data", 32'(DATA),      32'd0);
        chk("rs_uf_sticky",   32'(underflow), 32'd1);
        step();
        Data_Req = 1'b1;
        #1;
        chk("rs_pop0", 32'(DATA), 32'd0);
        step();
        chk("rs_pop1", 32'(DATA), 32'd1);
        step();
        chk("rs_pop2", 32'(DATA), 32'd2);
        step();
        Data_Req = 1'b0;
        #1;
        for (int i = 0; i < 24; i++) step();
        wr_req = 1'b1; wr_addr = 19'd33; wr_data = 24'h333333;
        #1;
        chk("f3_stream_wr_ack", 32'(wr_ack), 32'd1);

        // Reset pulse mid-STREAM.
        step();
        Reset_n = 1'b0; Data_Req = 1'b1;
        #1;
        chk("mrst_data",      32'(DATA),        32'd0);
        chk("mrst_mem_en",    32'(mem_en),      32'd0);
        chk("mrst_mem_we",    32'(mem_we),      32'd0);
        chk("mrst_mem_addr",  32'(mem_addr),    32'd0);
        chk("mrst_mem_wdata", 32'(mem_wdata),   32'd0);
        chk("mrst_wr_ack",    32'(wr_ack),      32'd0);
        chk("mrst_underflow", 32'(underflow),   32'd0);
        chk("mrst_fstart",    32'(frame_start), 32'd0);
        step();
        step();
        Reset_n = 1'b1; wr_req = 1'b0; Data_Req = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("post_mem_en", 32'(mem_en), 32'd0);
            chk("post_data",   32'(DATA),   32'd0);
            step();
        end
        wr_req = 1'b1; wr_addr = 19'd77; wr_data = 24'h777777;
        #1;
        chk("post_wr_ack",   32'(wr_ack),   32'd1);
        chk("post_mem_addr", 32'(mem_addr), 32'd77);
        step();
        wr_req = 1'b0;
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
